// File: rtl/mop_seq_accumulator_if.sv
// Operand-in / result-out stream bundle for the sequential m-operand accumulator.
interface mop_seq_accumulator_if #(
    parameter int WIDTH    = 64,
    parameter int OPERANDS = 8
);
    localparam int SUM_W = WIDTH + $clog2(OPERANDS);
    localparam int CNT_W = $clog2(OPERANDS + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [SUM_W-1:0] out_sum;
    logic [CNT_W-1:0] out_count;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_count
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_count
    );
endinterface

// File: rtl/mop_seq_accumulator.sv
// Sequential m-operand adder: one 3:2 CSA row per operand beat, then a chunked
// carry-propagate pass that resolves the (sum, carry) pair CHUNK bits per cycle.
//
//   state   | meaning
//   ACC     | accepting operands, folding each into S/C
//   RESOLVE | rippling S+C into out_sum one chunk per cycle
//   DONE    | result presented, waiting for out_ready
module mop_seq_accumulator #(
    parameter int WIDTH    = 64,
    parameter int OPERANDS = 8,
    parameter int CHUNK    = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    mop_seq_accumulator_if.slave   bus
);
    localparam int SUM_W  = WIDTH + $clog2(OPERANDS);
    localparam int NCHUNK = (SUM_W + CHUNK - 1) / CHUNK;
    localparam int CNT_W  = $clog2(OPERANDS + 1);
    localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {ACC, RESOLVE, DONE} state_t;

    state_t           state_q, state_d;
    logic [SUM_W-1:0] s_q, s_d, c_q, c_d, sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, outcnt_q, outcnt_d;
    logic [KW-1:0]    k_q, k_d;
    logic             cr_q, cr_d;
    logic             in_ready_q, in_ready_d, out_valid_q, out_valid_d;

    logic             accept, last_chunk;
    logic [SUM_W-1:0] x;
    logic [CHUNK-1:0] a, b;
    logic [CHUNK:0]   chunk_sum;

    assign x          = SUM_W'(bus.in_data);
    assign accept     = bus.in_valid && in_ready_q;
    assign last_chunk = (k_q == KW'(NCHUNK - 1));

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = sum_q;
    assign bus.out_count = outcnt_q;

    // Select chunk k of S and C; bits past SUM_W in the last chunk read as zero.
    always_comb begin
        a = '0;
        b = '0;
        for (int j = 0; j < SUM_W; j++) begin
            if (k_q == KW'(j / CHUNK)) begin
                a[j % CHUNK] = s_q[j];
                b[j % CHUNK] = c_q[j];
            end
        end
        chunk_sum = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cr_q};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ACC;
            s_q         <= '0;
            c_q         <= '0;
            sum_q       <= '0;
            cnt_q       <= '0;
            outcnt_q    <= '0;
            k_q         <= '0;
            cr_q        <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            c_q         <= c_d;
            sum_q       <= sum_d;
            cnt_q       <= cnt_d;
            outcnt_q    <= outcnt_d;
            k_q         <= k_d;
            cr_q        <= cr_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ACC:     if (accept && (bus.in_last || cnt_d == CNT_W'(OPERANDS))) state_d = RESOLVE;
            RESOLVE: if (last_chunk) state_d = DONE;
            DONE:    if (bus.out_ready) state_d = ACC;
            default: state_d = ACC;
        endcase
    end

    always_comb begin
        s_d      = s_q;
        c_d      = c_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        outcnt_d = outcnt_q;
        k_d      = k_q;
        cr_d     = cr_q;
        if (accept) begin
            s_d   = s_q ^ c_q ^ x;
            c_d   = ((s_q & c_q) | (s_q & x) | (c_q & x)) << 1;
            cnt_d = cnt_q + CNT_W'(1);
            k_d   = '0;
            cr_d  = 1'b0;
        end
        if (state_q == RESOLVE) begin
            for (int j = 0; j < SUM_W; j++) begin
                if (k_q == KW'(j / CHUNK)) sum_d[j] = chunk_sum[j % CHUNK];
            end
            cr_d = chunk_sum[CHUNK];
            k_d  = k_q + KW'(1);
            if (last_chunk) outcnt_d = cnt_q;
        end
        if (state_q == DONE && bus.out_ready) begin
            s_d   = '0;
            c_d   = '0;
            cnt_d = '0;
        end
        in_ready_d  = (state_d == ACC);
        out_valid_d = (state_d == DONE);
    end
endmodule

// File: tb/tb_mop_seq_accumulator.sv
// Directed bench for mop_seq_accumulator: WIDTH=8, OPERANDS=4 with CHUNK=4, 3 and 10.
module tb_mop_seq_accumulator;
    localparam int SW = 10;
    localparam int CW = 3;
    localparam int NCH [3] = '{3, 4, 1};

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid_v  [3];
    logic          out_ready_v [3];
    logic [7:0]    in_data;
    logic          in_last;
    logic          in_ready_v  [3];
    logic          out_valid_v [3];
    logic [SW-1:0] out_sum_v   [3];
    logic [CW-1:0] out_count_v [3];

    int total  = 0;
    int passed = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int CH = (g == 0) ? 4 : ((g == 1) ? 3 : 10);
        mop_seq_accumulator_if #(.WIDTH(8), .OPERANDS(4)) bus ();
        assign bus.in_valid   = in_valid_v[g];
        assign bus.in_data    = in_data;
        assign bus.in_last    = in_last;
        assign bus.out_ready  = out_ready_v[g];
        assign in_ready_v[g]  = bus.in_ready;
        assign out_valid_v[g] = bus.out_valid;
        assign out_sum_v[g]   = bus.out_sum;
        assign out_count_v[g] = bus.out_count;
        mop_seq_accumulator #(.WIDTH(8), .OPERANDS(4), .CHUNK(CH)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus.slave)
        );
    end

    task automatic chk(input string tag, input int d, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s dut%0d: observed %0d expected %0d", tag, d, got, exp);
        end
    endtask

    // Offer one beat starting on a falling edge; returns just after the accepting edge.
    task automatic send(input int d, input logic [7:0] x, input logic last, input int gap);
        int n;
        repeat (gap + 1) @(negedge clk);
        in_valid_v[d] = 1'b1;
        in_data       = x;
        in_last       = last;
        n = 0;
        while (!in_ready_v[d] && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait", d, 64'(n < 100), 64'd1);
        @(posedge clk);
        #1;
        in_valid_v[d] = 1'b0;
    endtask

    // Called right after the final accepting edge; checks latency, value, hold and handshake.
    task automatic get_result(input int d, input logic [SW-1:0] es, input logic [CW-1:0] ec,
                              input int hold);
        int lat;
        lat = 0;
        while (!out_valid_v[d] && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", d, 64'(lat), 64'(NCH[d]));
        chk("sum", d, 64'(out_sum_v[d]), 64'(es));
        chk("count", d, 64'(out_count_v[d]), 64'(ec));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", d, 64'(out_valid_v[d]), 64'd1);
            chk("hold_sum", d, 64'(out_sum_v[d]), 64'(es));
            chk("hold_count", d, 64'(out_count_v[d]), 64'(ec));
            chk("hold_ready", d, 64'(in_ready_v[d]), 64'd0);
        end
        @(negedge clk);
        out_ready_v[d] = 1'b1;
        @(posedge clk);
        #1;
        out_ready_v[d] = 1'b0;
        chk("valid_drop", d, 64'(out_valid_v[d]), 64'd0);
        chk("ready_back", d, 64'(in_ready_v[d]), 64'd1);
    endtask

    initial begin
        int          len;
        bit          auto_t;
        logic [SW-1:0] es;
        logic [7:0]  v;

        for (int d = 0; d < 3; d++) begin
            in_valid_v[d]  = 1'b0;
            out_ready_v[d] = 1'b0;
        end
        in_data = '0;
        in_last = 1'b0;
        rst_n   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("rst_ready", d, 64'(in_ready_v[d]), 64'd0);
            chk("rst_valid", d, 64'(out_valid_v[d]), 64'd0);
            chk("rst_sum", d, 64'(out_sum_v[d]), 64'd0);
            chk("rst_count", d, 64'(out_count_v[d]), 64'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) chk("ready_after_rst", d, 64'(in_ready_v[d]), 64'd1);

        // four max operands, explicit last
        send(0, 8'd255, 1'b0, 0);
        send(0, 8'd255, 1'b0, 0);
        send(0, 8'd255, 1'b0, 0);
        send(0, 8'd255, 1'b1, 0);
        get_result(0, 10'd1020, 3'd4, 0);

        // auto-terminate at OPERANDS; fifth beat must wait for the next sum
        send(0, 8'd1, 1'b0, 0);
        send(0, 8'd2, 1'b0, 0);
        send(0, 8'd3, 1'b0, 0);
        send(0, 8'd4, 1'b0, 0);
        chk("auto_term_ready", 0, 64'(in_ready_v[0]), 64'd0);
        @(negedge clk);
        in_valid_v[0] = 1'b1;
        in_data       = 8'd5;
        in_last       = 1'b0;
        get_result(0, 10'd10, 3'd4, 0);
        @(posedge clk);
        #1;
        in_valid_v[0] = 1'b0;
        send(0, 8'd6, 1'b1, 0);
        get_result(0, 10'd11, 3'd2, 0);

        // single operand
        send(0, 8'h5A, 1'b1, 0);
        get_result(0, 10'd90, 3'd1, 0);

        // backpressure for ten cycles
        send(0, 8'd100, 1'b0, 0);
        send(0, 8'd50, 1'b1, 0);
        get_result(0, 10'd150, 3'd2, 10);

        // reset while resolving chunk 1
        send(0, 8'd3, 1'b0, 0);
        send(0, 8'd4, 1'b1, 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_valid", 0, 64'(out_valid_v[0]), 64'd0);
        chk("midrst_ready", 0, 64'(in_ready_v[0]), 64'd0);
        chk("midrst_sum", 0, 64'(out_sum_v[0]), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("postrst_ready", 0, 64'(in_ready_v[0]), 64'd1);
        repeat (4) begin
            @(negedge clk);
            chk("postrst_no_result", 0, 64'(out_valid_v[0]), 64'd0);
        end
        send(0, 8'd7, 1'b0, 0);
        send(0, 8'd8, 1'b1, 0);
        get_result(0, 10'd15, 3'd2, 0);

        // random sums on the non-dividing and single-chunk configurations
        for (int d = 1; d < 3; d++) begin
            for (int r = 0; r < 150; r++) begin
                len    = int'($urandom_range(1, 4));
                auto_t = (len == 4) && ($urandom_range(0, 1) == 1);
                es     = '0;
                for (int i = 0; i < len; i++) begin
                    v  = 8'($urandom);
                    es = es + SW'(v);
                    send(d, v, (i == len - 1) && !auto_t, int'($urandom_range(0, 2)));
                end
                get_result(d, es, CW'(len), int'($urandom_range(0, 3)));
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
